// File: rtl/store_queue_ctrl.sv
// Store queue between the processor store port and the cache write port: SECDED-tagged FIFO,
// output register and fence sequencing. Optional ack watchdog: STORE_QUEUE_CTRL_ACK_TIMEOUT_EN.
module store_queue_ctrl #(
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = 32,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid_PC,
   output logic                     st_ready_PC,
   input  logic [ADDR_W-1:0]        addr_PC,
   input  logic [31:0]              data_PC,
   input  logic                     special_store_PC,
   output logic                     wr_req_Cache,
   input  logic                     wr_ack_Cache,
   output logic [ADDR_W-1:0]        addr_Cache,
   output logic [31:0]              data_Cache,
   output logic [6:0]               parity_Cache,
   output logic                     special_store_Cache,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     idle,
   output logic                     ack_timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = ADDR_W + 40;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_FENCE = 2'd2;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("store_queue_ctrl: DEPTH must be a power of two >= 2");
   end
   if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_timeout
      $error("store_queue_ctrl: ACK_TIMEOUT must be 1..255");
   end

   // Hamming(38,32): each set data bit folds its codeword position into the syndrome;
   // data occupies the non-power-of-two positions 3..38. Bit 6 is overall parity (DED).
   function automatic logic [6:0] secded(input logic [31:0] d);
      logic [5:0] syn;
      logic [5:0] pos;
      syn = '0;
      pos = 6'd2;
      for (int i = 0; i < 32; i++) begin
         pos = pos + 6'd1;
         if ((pos & (pos - 6'd1)) == 6'd0) pos = pos + 6'd1;
         if (d[i]) syn = syn ^ pos;
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [EW-1:0] out_q, out_d;
   logic [EW-1:0] mem_q [DEPTH];

   logic [PW-1:0] count;
   logic          full, empty, push, pop;
   logic [EW-1:0] head, entry_in;
   logic          head_special, fence_pend;

   assign count        = wr_ptr_q - rd_ptr_q;
   assign full         = (count == PW'(DEPTH));
   assign empty        = (count == '0);
   assign head         = mem_q[rd_ptr_q[AW-1:0]];
   assign head_special = head[0];
   assign entry_in     = {addr_PC, data_PC, secded(data_PC), special_store_PC};

   // A special waiting in the FIFO already closes admission, so nothing can slip in behind it
   // during the cycle before it is moved into the output register.
   assign fence_pend = !empty & head_special;

   assign idle        = empty & (state_q == S_IDLE);
   assign st_ready_PC = rst_n & !full & (state_q != S_FENCE) & !fence_pend
                        & !(special_store_PC & !idle);
   assign push        = st_valid_PC & st_ready_PC;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = head_special ? S_FENCE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wr_ack_Cache) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = head_special ? S_FENCE : S_ISSUE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_FENCE: begin
            if (wr_ack_Cache) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      out_d    = pop ? head : out_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
      end
   end

   // Storage is qualified by the pointers, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
   end

   assign wr_req_Cache        = (state_q != S_IDLE);
   assign addr_Cache          = out_q[EW-1 -: ADDR_W];
   assign data_Cache          = out_q[39:8];
   assign parity_Cache        = out_q[7:1];
   assign special_store_Cache = out_q[0];
   assign q_count             = count;

`ifdef STORE_QUEUE_CTRL_ACK_TIMEOUT_EN
   localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == TMO) ? v : v + 8'd1;
   endfunction

   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       err_q, err_d;

   always_comb begin
      wd_cnt_d = (!wr_req_Cache || wr_ack_Cache) ? 8'd0 : sat_inc(wd_cnt_q);
      err_d    = err_q | (wd_cnt_q == TMO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign ack_timeout_err = err_q;
`else
   assign ack_timeout_err = 1'b0;
`endif

endmodule

// File: doc/store_queue_ctrl.md
# store_queue_ctrl

Buffers processor stores and sequences their delivery into the cache write port. Each accepted store is SECDED-encoded at enqueue time by the existing `Parity_Encoder` (6 Hamming bits plus 1 DED bit), held in a small FIFO, and issued to the cache over a req/ack handshake. Special stores act as fences: they are issued alone, with no other store queued ahead or admitted behind. Sits between the processor store port and the cache, replacing the purely combinational store path.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: store address width.
- `ACK_TIMEOUT`, 15: cycles of `wr_req_Cache` without `wr_ack_Cache` before timeout (watchdog builds only); 1..255.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid_PC` in 1: processor store request.
- `st_ready_PC` out 1: store accepted on the rising edge where `st_valid_PC & st_ready_PC`.
- `addr_PC` in ADDR_W: store address.
- `data_PC` in 32: store data.
- `special_store_PC` in 1: fence/special store flag.
- `wr_req_Cache` out 1: cache write request.
- `wr_ack_Cache` in 1: cache accepts the presented write this cycle.
- `addr_Cache` out ADDR_W: write address.
- `data_Cache` out 32: write data.
- `parity_Cache` out 7: [5:0] Hamming, [6] DED.
- `special_store_Cache` out 1: special flag of presented write.
- `q_count` out $clog2(DEPTH)+1: FIFO occupancy, excluding the entry in the output register.
- `idle` out 1: FIFO empty and FSM in IDLE.
- `ack_timeout_err` out 1: sticky watchdog error.

## Operation

- Entry = {addr, data, parity[6:0], special}. Parity is computed combinationally from `data_PC` at enqueue and stored with the entry. It is never recomputed.
- `st_ready_PC` = !full & (state != FENCE) & !(special_store_PC & !idle).
  - A special store is admitted only when the whole unit is idle.
  - This ready signal has a combinational dependence on `special_store_PC`.
- Full FIFO: ready is low even if a pop occurs the same cycle. There is no enqueue-on-pop when full.
- Output register holds the presented write. `addr_Cache`, `data_Cache`, `parity_Cache` and `special_store_Cache` stay stable while `wr_req_Cache` is high.

FSM:
- IDLE: if FIFO non-empty, pop the head into the output register.
  - Head special → FENCE.
  - Otherwise → ISSUE.
- ISSUE: `wr_req_Cache`=1. On `wr_ack_Cache`:
  - If FIFO non-empty, pop the next entry into the output register the same edge and stay in ISSUE (special head → FENCE).
  - If FIFO empty → IDLE.
- FENCE: `wr_req_Cache`=1 with the special entry. `st_ready_PC`=0. On `wr_ack_Cache` → IDLE.
- A special entry can only reach the head with nothing behind it, because admission requires idle and ready is low in FENCE.
- `wr_ack_Cache` while `wr_req_Cache`=0 is ignored.

Reset:
- All outputs are 0 during and after reset: `st_ready_PC`=0 while `rst_n`=0, `wr_req_Cache`=0, all data outputs 0, `q_count`=0, `ack_timeout_err`=0.
- `idle`=1 after reset.
- Mid-operation reset discards all queued and in-flight stores. `wr_req_Cache` drops asynchronously.

## Timing

- Enqueue at edge N into an idle unit: entry is in the FIFO at N+1, loaded into the output register at edge N+1, and `wr_req_Cache` is high in cycle N+2.
- Throughput in ISSUE: one store per cycle while `wr_ack_Cache` is held high and the FIFO is non-empty.
- `q_count` updates the cycle after enqueue or pop. Simultaneous enqueue and pop leaves it unchanged.
- `idle` is registered-state derived, with no combinational path from inputs.

## Configuration

Macro `STORE_QUEUE_CTRL_ACK_TIMEOUT_EN`.

Defined:
- An 8-bit counter clears on every edge where `wr_req_Cache`=0 or `wr_ack_Cache`=1, and increments otherwise.
- When it reaches `ACK_TIMEOUT`, `ack_timeout_err` sets the next cycle and stays set until reset. The counter saturates.
- The request stays asserted. Operation is otherwise unchanged.

Undefined:
- No counter is built. `ack_timeout_err` is tied to 0.

## Test plan

- Single store `addr`=0x100, `data`=0x00000000 into an idle unit → `wr_req_Cache` high exactly 2 cycles after the handshake. `parity_Cache` equals the `Parity_Encoder` output for 0x0 (expected 7'h00). Ack → `idle`=1 the next cycle.
- DEPTH=4, `wr_ack_Cache`=0, 6 back-to-back stores → 5 accepted (1 in the output register, 4 queued), `q_count`=4, `st_ready_PC`=0. Then hold ack=1 → 5 writes in order on consecutive cycles, `q_count` reaches 0.
- Special store issued while 2 stores are queued → `st_ready_PC`=0 until `idle`. Then accepted, FENCE reached. A normal store offered during FENCE is stalled until the cycle after the special's ack.
- Reset asserted while in ISSUE with 3 queued → `wr_req_Cache` falls immediately and `q_count`=0. After release, `st_ready_PC`=1 and no stale write is issued.
- With `STORE_QUEUE_CTRL_ACK_TIMEOUT_EN`, `ACK_TIMEOUT`=15: withhold ack for 20 cycles → `ack_timeout_err` rises after 15 un-acked request cycles and stays set after a later ack. Without the macro, the same stimulus keeps it at 0.
- Data 0xFFFFFFFF and 0xA5A5A5A5 → `parity_Cache` matches the encoder reference model for each value, including bit 6 (DED).
